// File: rtl/memory_manager_bridge.sv
// ---------------------------------------------------------------------------
// memory_manager_bridge
//
// Bridges a narrow host byte bus onto a wide per-core word bus. The host
// byte address is split into a byte lane, a core word address and a core
// index. Host writes are assembled from an even-lane byte (held) and an
// odd-lane byte (which commits the full word and pulses wren_out). Host reads
// capture one byte lane of the core word into a read register that drives
// the host data bus.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   rst_n        : synchronous active-low reset
//   data         : host byte bus (inout), driven by the bridge while wren_in=0
//   address      : host byte address {core index, word address, lane}
//   wren_in      : 1 = host write, 0 = host read
//   core_data    : core word bus (inout), driven by the bridge while wren_in=1
//   core_address : registered core word address
//   wren_out     : registered core write strobe
//   reg_en       : registered one-hot register-window select
//   core_en      : registered one-hot core select
// ---------------------------------------------------------------------------
module memory_manager_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SPACE = 23,
  parameter int CORE_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int NUM_CORES  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_SPACE-1:0] address,
  input  logic                  wren_in,
  inout  logic [CORE_WIDTH-1:0] core_data,
  output logic [CORE_WIDTH-1:0] core_address,
  output logic                  wren_out,
  output logic [NUM_REGS-1:0]   reg_en,
  output logic [NUM_CORES-1:0]  core_en
);

  // Address field boundaries: bit 0 is the lane, the next CORE_WIDTH bits
  // are the word address, the remaining upper bits are the core index.
  localparam int WORD_LSB     = 1;
  localparam int WORD_MSB     = CORE_WIDTH;
  localparam int CORE_LSB     = CORE_WIDTH + 1;
  localparam int CORE_MSB     = ADDR_SPACE - 1;
  localparam int REG_SEL_BITS = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_lowHold;
  logic [CORE_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] r_read;

  logic                  w_lane;
  logic                  w_regHit;
  logic [NUM_REGS-1:0]   w_regOneHot;
  logic [NUM_CORES-1:0]  w_coreOneHot;

  assign w_lane = address[0];

  // The register window is the top NUM_REGS words of each core's space:
  // every word-address bit above the register select must be one.
  assign w_regHit     = &address[WORD_MSB:REG_SEL_BITS+WORD_LSB];
  assign w_regOneHot  = NUM_REGS'(1) << address[REG_SEL_BITS:WORD_LSB];
  assign w_coreOneHot = NUM_CORES'(1) << address[CORE_MSB:CORE_LSB];

  // Bus direction follows wren_in alone, so switching to read releases the
  // core bus in the same cycle and reset never forces a direction.
  assign core_data = wren_in ? r_word : {CORE_WIDTH{1'bz}};
  assign data      = wren_in ? {DATA_WIDTH{1'bz}} : r_read;

  // All registered outputs and holding registers. Reset wins over any write
  // or read on the same edge, which also discards a half-assembled word.
  // wren_out defaults low every edge and is only raised by an odd-lane write,
  // so a held odd-lane write simply re-commits the same word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_address <= '0;
      core_en      <= '0;
      reg_en       <= '0;
      wren_out     <= 1'b0;
      r_lowHold    <= '0;
      r_word       <= '0;
      r_read       <= '0;
    end else begin
      core_address <= address[WORD_MSB:WORD_LSB];
      core_en      <= w_coreOneHot;
      reg_en       <= w_regHit ? w_regOneHot : '0;
      wren_out     <= 1'b0;
      if (wren_in) begin
        if (!w_lane) begin
          r_lowHold <= data;
        end else begin
          r_word   <= {data, r_lowHold};
          wren_out <= 1'b1;
        end
      end else begin
        r_read <= w_lane ? core_data[2*DATA_WIDTH-1:DATA_WIDTH]
                         : core_data[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_memory_manager_bridge.sv
// ---------------------------------------------------------------------------
// tb_memory_manager_bridge
//
// Drives host writes and reads into memory_manager_bridge. Each odd-lane
// write pushes the expected committed word onto a scoreboard; a monitor pops
// one entry per wren_out group and compares address, word and selects.
// ---------------------------------------------------------------------------
module tb_memory_manager_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [22:0] address;
  logic        wren_in;
  logic [7:0]  hostData;
  logic [15:0] coreWord;
  wire  [7:0]  data;
  wire  [15:0] core_data;
  logic [15:0] core_address;
  logic        wren_out;
  logic [7:0]  reg_en;
  logic [63:0] core_en;

  always #5 clk = ~clk;

  // Host drives the byte bus while writing; the core drives its bus while
  // the host reads.
  assign data      = wren_in ? hostData : 8'bz;
  assign core_data = wren_in ? 16'bz : coreWord;

  memory_manager_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .address      (address),
    .wren_in      (wren_in),
    .core_data    (core_data),
    .core_address (core_address),
    .wren_out     (wren_out),
    .reg_en       (reg_en),
    .core_en      (core_en)
  );

  typedef struct {
    string       tag;
    logic [15:0] addr;
    logic [15:0] word;
    logic [7:0]  regEn;
    logic [63:0] coreEn;
  } expWrite_t;

  expWrite_t   sbQueue[$];
  expWrite_t   lastExp;
  int          checkCount = 0;
  int          passCount  = 0;
  int          pushCount  = 0;
  int          groupCount = 0;
  logic [7:0]  modelLow   = 8'd0;
  logic        prevWren   = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [7:0] regModel(input logic [15:0] w);
    logic [7:0] one = 8'd1;
    regModel = (w[15:3] == 13'h1fff) ? (one << w[2:0]) : 8'd0;
  endfunction

  // One host write held for a number of edges; an odd lane pushes the word
  // that should be committed, built from the last even-lane byte.
  task automatic applyStimulus(input logic [22:0] addr, input logic [7:0] dat,
                               input int cycles, input string tag);
    expWrite_t   e;
    logic [63:0] one = 64'd1;
    @(negedge clk);
    wren_in  = 1'b1;
    address  = addr;
    hostData = dat;
    if (!addr[0]) begin
      modelLow = dat;
    end else begin
      e.tag    = tag;
      e.addr   = addr[16:1];
      e.word   = {dat, modelLow};
      e.regEn  = regModel(addr[16:1]);
      e.coreEn = one << addr[22:17];
      sbQueue.push_back(e);
      pushCount++;
    end
    repeat (cycles) @(posedge clk);
  endtask

  task automatic readByte(input logic [22:0] addr, input logic [15:0] word,
                          input logic [7:0] expected, input string tag);
    @(negedge clk);
    wren_in  = 1'b0;
    address  = addr;
    coreWord = word;
    @(posedge clk);
    #1;
    checkOutput(tag, {56'd0, data}, {56'd0, expected});
  endtask

  // Monitor: a rising wren_out starts a new group and consumes one
  // scoreboard entry; further cycles of the same group must repeat it.
  always @(posedge clk) begin
    #1;
    if (wren_out) begin
      if (!prevWren) begin
        groupCount++;
        if (sbQueue.size() == 0) begin
          checkOutput("sbUnderflow", 64'd1, 64'd0);
        end else begin
          lastExp = sbQueue.pop_front();
          checkOutput({lastExp.tag, "_addr"}, {48'd0, core_address}, {48'd0, lastExp.addr});
          checkOutput({lastExp.tag, "_word"}, {48'd0, core_data}, {48'd0, lastExp.word});
          checkOutput({lastExp.tag, "_core"}, core_en, lastExp.coreEn);
          checkOutput({lastExp.tag, "_reg"}, {56'd0, reg_en}, {56'd0, lastExp.regEn});
        end
      end else begin
        checkOutput({lastExp.tag, "_holdWord"}, {48'd0, core_data}, {48'd0, lastExp.word});
        checkOutput({lastExp.tag, "_holdAddr"}, {48'd0, core_address}, {48'd0, lastExp.addr});
      end
    end
    prevWren = wren_out;
  end

  initial begin
    rst_n    = 1'b0;
    wren_in  = 1'b0;
    address  = 23'd0;
    hostData = 8'd0;
    coreWord = 16'h5A5A;

    // Reset state, with the bridge owning the host bus.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstAddr", {48'd0, core_address}, 64'd0);
    checkOutput("rstCoreEn", core_en, 64'd0);
    checkOutput("rstRegEn", {56'd0, reg_en}, 64'd0);
    checkOutput("rstWren", {63'd0, wren_out}, 64'd0);
    checkOutput("rstData", {56'd0, data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Byte pair, each lane held two edges.
    applyStimulus(23'd4, 8'h04, 2, "pair");
    applyStimulus(23'd5, 8'h00, 2, "pair");

    // Reads of both lanes, and a pattern that would be corrupted if the
    // bridge also drove core_data (its write word is 0x0004).
    readByte(23'd0, 16'h1234, 8'h34, "readLo");
    readByte(23'd1, 16'h1234, 8'h12, "readHi");
    readByte(23'd0, 16'h00F0, 8'hF0, "readUndriven");

    // Highest word address of core 0 lands in the register window.
    readByte({6'd0, 16'hFFFF, 1'b1}, 16'hBEEF, 8'hBE, "readTop");
    checkOutput("topAddr", {48'd0, core_address}, 64'h0000_0000_0000_FFFF);
    checkOutput("topRegEn", {56'd0, reg_en}, 64'h80);
    checkOutput("topCoreEn", core_en, 64'd1);

    // Core select.
    applyStimulus(23'h020002, 8'hAB, 1, "coreSel");
    applyStimulus(23'h020003, 8'hCD, 1, "coreSel");

    // Register window write at word 0xFFFA.
    applyStimulus({6'd0, 16'hFFFA, 1'b0}, 8'h11, 1, "regWin");
    applyStimulus({6'd0, 16'hFFFA, 1'b1}, 8'h22, 1, "regWin");

    // Reset between lanes, asserted on top of an odd-lane write.
    applyStimulus(23'h000010, 8'h55, 1, "rstMid");
    @(negedge clk);
    rst_n    = 1'b0;
    wren_in  = 1'b1;
    address  = 23'h000011;
    hostData = 8'h77;
    @(posedge clk);
    #1;
    checkOutput("midRstAddr", {48'd0, core_address}, 64'd0);
    checkOutput("midRstCoreEn", core_en, 64'd0);
    checkOutput("midRstRegEn", {56'd0, reg_en}, 64'd0);
    checkOutput("midRstWren", {63'd0, wren_out}, 64'd0);
    checkOutput("midRstWord", {48'd0, core_data}, 64'd0);
    modelLow = 8'd0;
    @(negedge clk);
    rst_n   = 1'b1;
    wren_in = 1'b0;
    applyStimulus(23'h000011, 8'h66, 1, "rstMid");

    // Sweep: word n at core address n carries 2n.
    for (int i = 0; i < 128; i++) begin
      applyStimulus(23'(i), (i % 2 == 1) ? 8'd0 : 8'(i), 1, "sweep");
    end

    @(negedge clk);
    wren_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("sbEmpty", 64'(sbQueue.size()), 64'd0);
    checkOutput("groups", 64'(groupCount), 64'(pushCount));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/memory_manager_bridge.md
MEMORY_MANAGER_BRIDGE -- requirements
Module: memory_manager

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 8, host data width.
- ADDR_SPACE, 23, host byte-address width.
- CORE_WIDTH, 16, core data and word-address width.
- NUM_REGS, 8, register-window size.
- NUM_CORES, 64, number of cores.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset; synchronous and active-low.
- data, inout, DATA_WIDTH, host byte bus.
- address, input, ADDR_SPACE, host byte address.
- wren_in, input, 1, 1 = host writes, 0 = host reads.
- core_data, inout, CORE_WIDTH, core word bus.
- core_address, output, CORE_WIDTH, core word address.
- wren_out, output, 1, core write strobe.
- reg_en, output, NUM_REGS, one-hot register-window select.
- core_en, output, NUM_CORES, one-hot core select.

Function
REQ-003 The block SHALL decode the host address as follows.
- address[0] is the byte lane: 0 = LS byte, 1 = MS byte.
- address[16:1] is the word address.
- address[22:17] is the core index.
REQ-004 Each clock edge SHALL register these outputs:
- core_address <= address[16:1];
- core_en <= one-hot of address[22:17].
REQ-005 Each clock edge SHALL register reg_en.
- When address[16:4] is all ones, reg_en <= one-hot of address[3:1].
- Otherwise reg_en <= 0.
REQ-006 Write, even lane: on an edge with wren_in=1 and address[0]=0, the block SHALL latch data into an internal low-byte holding register.
REQ-007 Write, odd lane: on an edge with wren_in=1 and address[0]=1, the block SHALL register the output word {data, low_hold} and set wren_out=1 for the following cycle.
REQ-008 On every other edge, wren_out SHALL be 0; a held odd-lane write re-asserts wren_out with the same word, and this is idempotent.
REQ-009 If an odd-lane write arrives with no preceding even-lane write, the block SHALL use the current low_hold value, which is 0 after reset.
REQ-010 core_data SHALL be driven with the registered word only while wren_in=1; otherwise it SHALL be high-Z.
REQ-011 data SHALL be driven by the block only while wren_in=0; otherwise it SHALL be high-Z.
REQ-012 Read: each edge with wren_in=0 SHALL capture into a read register:
- core_data[7:0] when address[0]=0;
- core_data[15:8] when address[0]=1.
REQ-013 The read register SHALL drive data, so read latency is one cycle after core_data is valid and two edges after address is stable for a combinational core.
REQ-014 Switching wren_in from 1 to 0 SHALL release core_data in the same cycle, combinationally; there is no bus-turnaround cycle.
REQ-015 Address bits are used unmodified, so any word address 0..65535 is reachable with no wrap logic.

Reset
REQ-016 When rst_n=0 at a clock edge, all of the following SHALL be cleared at that edge:
- core_address, core_en, reg_en, wren_out;
- low_hold, the write word and the read register.
REQ-017 Reset SHALL take priority over a simultaneous write or read.
REQ-018 A reset between an even-lane write and its odd-lane write SHALL discard the held low byte.
REQ-019 The tri-state enables SHALL depend only on wren_in, so reset does not force a bus direction.

Verification
REQ-020 Byte-pair write: wren_in=1, addr 4 data 0x04, then addr 5 data 0x00, each held 2 cycles.
- Required: core_address=2, core_data=0x0004, wren_out=1, core_en=bit0.
REQ-021 Core select: write addr 23'h020002 data 0xAB, then 23'h020003 data 0xCD.
- Required: core_en=bit1, core_address=1, core_data=0xCDAB.
REQ-022 Register window: host address word field 0xFFFA.
- Required: reg_en=8'b0000_0100.
- Word 0x0002 gives reg_en=0.
REQ-023 Read: wren_in=0, core drives 0x1234.
- addr 0 gives data=0x34 after one edge.
- addr 1 gives data=0x12.
- core_data is undriven by the block.
REQ-024 Reset mid-write: write the even lane with 0x55, pulse rst_n=0 for one edge, then write the odd lane with 0x66.
- Required: word=0x6600.
- All outputs are 0 during reset.
REQ-025 Write sweep: 128 bytes at addr i with data (i odd ? 0 : i).
- Required: word n written at core_address n with value 2n.
- Exactly one wren_out group per odd address.
